// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-port alu arbiter and its alu datapath.
package alu_arbiter_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned MSB    = DATA_W - 1;

    localparam logic ALU_SEL_AU = 1'b0;
    localparam logic ALU_SEL_LU = 1'b1;

    // Arithmetic unit opcode map
    localparam logic [OP_W-1:0] ALU_OP_ADD  = 3'd0;
    localparam logic [OP_W-1:0] ALU_OP_SUB  = 3'd1;
    localparam logic [OP_W-1:0] ALU_OP_INC  = 3'd2;
    localparam logic [OP_W-1:0] ALU_OP_DEC  = 3'd3;
    localparam logic [OP_W-1:0] ALU_OP_SHL  = 3'd4;
    localparam logic [OP_W-1:0] ALU_OP_SHR  = 3'd5;
    localparam logic [OP_W-1:0] ALU_OP_ASR  = 3'd6;
    localparam logic [OP_W-1:0] ALU_OP_PASS = 3'd7;

    // Logic unit opcode map
    localparam logic [OP_W-1:0] ALU_OP_AND   = 3'd0;
    localparam logic [OP_W-1:0] ALU_OP_OR    = 3'd1;
    localparam logic [OP_W-1:0] ALU_OP_XOR   = 3'd2;
    localparam logic [OP_W-1:0] ALU_OP_NOT   = 3'd3;
    localparam logic [OP_W-1:0] ALU_OP_NAND  = 3'd4;
    localparam logic [OP_W-1:0] ALU_OP_NOR   = 3'd5;
    localparam logic [OP_W-1:0] ALU_OP_XNOR  = 3'd6;
    localparam logic [OP_W-1:0] ALU_OP_PASSB = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic              sel;
        logic [OP_W-1:0]   opcode;
        logic [DATA_W-1:0] arg1;
        logic [DATA_W-1:0] arg2;
    } operand_t;

endpackage

// File: rtl/alu.sv
// 16-bit alu: arithmetic unit (sel=0) and logic unit (sel=1), purely combinational.
module alu
    import alu_arbiter_pkg::*;
(
    input  logic              sel,
    input  logic [OP_W-1:0]   opcode,
    input  logic [DATA_W-1:0] arg1,
    input  logic [DATA_W-1:0] arg2,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              overflow
);

    logic [DATA_W:0] wide;

    always_comb begin
        wide     = '0;
        result   = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        if (sel == ALU_SEL_AU) begin
            case (opcode)
                ALU_OP_ADD: begin
                    wide     = {1'b0, arg1} + {1'b0, arg2};
                    result   = wide[MSB:0];
                    carry    = wide[DATA_W];
                    overflow = (arg1[MSB] == arg2[MSB]) && (result[MSB] != arg1[MSB]);
                end
                ALU_OP_SUB: begin
                    wide     = {1'b0, arg1} - {1'b0, arg2};
                    result   = wide[MSB:0];
                    carry    = wide[DATA_W];
                    overflow = (arg1[MSB] != arg2[MSB]) && (result[MSB] != arg1[MSB]);
                end
                ALU_OP_INC: begin
                    wide     = {1'b0, arg1} + (DATA_W+1)'(1);
                    result   = wide[MSB:0];
                    carry    = wide[DATA_W];
                    overflow = !arg1[MSB] && result[MSB];
                end
                ALU_OP_DEC: begin
                    wide     = {1'b0, arg1} - (DATA_W+1)'(1);
                    result   = wide[MSB:0];
                    carry    = wide[DATA_W];
                    overflow = arg1[MSB] && !result[MSB];
                end
                ALU_OP_SHL: begin
                    result   = {arg1[MSB-1:0], 1'b0};
                    carry    = arg1[MSB];
                    overflow = arg1[MSB] ^ arg1[MSB-1];
                end
                ALU_OP_SHR: begin
                    result = {1'b0, arg1[MSB:1]};
                    carry  = arg1[0];
                end
                ALU_OP_ASR: begin
                    result = {arg1[MSB], arg1[MSB:1]};
                    carry  = arg1[0];
                end
                default: result = arg1;
            endcase
        end else begin
            case (opcode)
                ALU_OP_AND:  result = arg1 & arg2;
                ALU_OP_OR:   result = arg1 | arg2;
                ALU_OP_XOR:  result = arg1 ^ arg2;
                ALU_OP_NOT:  result = ~arg1;
                ALU_OP_NAND: result = ~(arg1 & arg2);
                ALU_OP_NOR:  result = ~(arg1 | arg2);
                ALU_OP_XNOR: result = ~(arg1 ^ arg2);
                default:     result = arg2;
            endcase
            // The logic unit leaves its sign bit on carry; callers must mask it.
            carry = result[MSB];
        end
    end

endmodule

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-input arbiter: round-robin against last_grant, or fixed priority to port 0.
module alu_arbiter_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       rr_enable,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        if (&req) begin
            grant = (rr_enable && !last_grant) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one alu between two valid/ready requesters: arbitrate, execute from
// registered operands, then hold a registered response until the winner accepts.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter logic RR_ENABLE = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_select,
    input  logic [5:0]  req_opcode,
    input  logic [31:0] req_arg1,
    input  logic [31:0] req_arg2,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [15:0] rsp_result,
    output logic        rsp_carry,
    output logic        rsp_overflow,
    output logic        busy,
    output logic [15:0] ops_done
);

    state_t            state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              last_grant_q, last_grant_d;
    operand_t          opnd_q, opnd_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              carry_q, carry_d;
    logic              ovf_q, ovf_d;
    logic [15:0]       ops_q, ops_d;

    logic [1:0]        grant;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;
    logic              alu_ovf;

    alu_arbiter_rr_arb2 u_rr_arb2 (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .rr_enable  (RR_ENABLE),
        .grant      (grant)
    );

    alu u_alu (
        .sel      (opnd_q.sel),
        .opcode   (opnd_q.opcode),
        .arg1     (opnd_q.arg1),
        .arg2     (opnd_q.arg2),
        .result   (alu_result),
        .carry    (alu_carry),
        .overflow (alu_ovf)
    );

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_grant_d = last_grant_q;
        opnd_d       = opnd_q;
        result_d     = result_q;
        carry_d      = carry_q;
        ovf_d        = ovf_q;
        ops_d        = ops_q;
        req_ready    = 2'b00;
        case (state_q)
            ST_IDLE: begin
                // Grant is suppressed while reset is held so nothing is accepted then.
                req_ready = rst_n ? grant : 2'b00;
                if (|grant) begin
                    gnt_d         = grant[1];
                    opnd_d.sel    = grant[1] ? req_select[1]     : req_select[0];
                    opnd_d.opcode = grant[1] ? req_opcode[5:3]   : req_opcode[2:0];
                    opnd_d.arg1   = grant[1] ? req_arg1[31:16]   : req_arg1[15:0];
                    opnd_d.arg2   = grant[1] ? req_arg2[31:16]   : req_arg2[15:0];
                    state_d       = ST_EXEC;
                end
            end
            ST_EXEC: begin
                result_d = alu_result;
                carry_d  = (opnd_q.sel == ALU_SEL_AU) ? alu_carry : 1'b0;
                ovf_d    = (opnd_q.sel == ALU_SEL_AU) ? alu_ovf   : 1'b0;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready[gnt_q]) begin
                    last_grant_d = gnt_q;
                    ops_d        = ops_q + 16'd1;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            gnt_q        <= 1'b0;
            last_grant_q <= 1'b1;
            opnd_q       <= '0;
            result_q     <= '0;
            carry_q      <= 1'b0;
            ovf_q        <= 1'b0;
            ops_q        <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            last_grant_q <= last_grant_d;
            opnd_q       <= opnd_d;
            result_q     <= result_d;
            carry_q      <= carry_d;
            ovf_q        <= ovf_d;
            ops_q        <= ops_d;
        end
    end

    assign rsp_valid    = (state_q == ST_RESP) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_result   = result_q;
    assign rsp_carry    = carry_q;
    assign rsp_overflow = ovf_q;
    assign busy         = (state_q != ST_IDLE);
    assign ops_done     = ops_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomised bench for alu_arbiter against a transaction-level model of the arbiter and alu.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid, req_ready, req_select, rsp_valid, rsp_ready;
    logic [5:0]  req_opcode;
    logic [31:0] req_arg1, req_arg2;
    logic [15:0] rsp_result, ops_done;
    logic        rsp_carry, rsp_overflow, busy;

    logic [1:0]  fp_req_valid, fp_req_ready, fp_rsp_valid;
    logic [15:0] fp_rsp_result, fp_ops_done;
    logic        fp_rsp_carry, fp_rsp_overflow, fp_busy;

    alu_arbiter #(.RR_ENABLE(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_select(req_select),
        .req_opcode(req_opcode), .req_arg1(req_arg1), .req_arg2(req_arg2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_carry(rsp_carry), .rsp_overflow(rsp_overflow), .busy(busy), .ops_done(ops_done)
    );

    alu_arbiter #(.RR_ENABLE(1'b0)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .req_valid(fp_req_valid), .req_ready(fp_req_ready), .req_select(2'b00),
        .req_opcode(6'd0), .req_arg1(32'h0001_0002), .req_arg2(32'h0003_0004),
        .rsp_valid(fp_rsp_valid), .rsp_ready(2'b11), .rsp_result(fp_rsp_result),
        .rsp_carry(fp_rsp_carry), .rsp_overflow(fp_rsp_overflow), .busy(fp_busy),
        .ops_done(fp_ops_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sel;
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
    } txn_t;

    txn_t        q0[$], q1[$];
    int          glog[$];
    int          n_cmp, n_err, cyc;
    int          m_owner, m_rsp_at;
    logic        m_last, m_c, m_v, in_rst, rsp_rand;
    logic [15:0] m_ops, m_res;
    logic [1:0]  rsp_force;
    logic [15:0] last_res;
    logic        last_c, last_v;
    int          fp_win, fp_p0, fp_p1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic txn_t mk(input logic s, input logic [2:0] op,
                                input logic [15:0] a, input logic [15:0] b);
        txn_t t;
        t.sel = s; t.op = op; t.a = a; t.b = b;
        return t;
    endfunction

    function automatic logic [15:0] rnd_arg();
        logic [15:0] edges [5] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
        if ($urandom_range(0, 2) == 0) return edges[$urandom_range(0, 4)];
        return 16'($urandom);
    endfunction

    function automatic txn_t rnd_txn();
        return mk(1'($urandom), 3'($urandom), rnd_arg(), rnd_arg());
    endfunction

    // Reference alu from integer arithmetic; logic-unit flags are always 0.
    function automatic void ref_alu(input txn_t t, output logic [15:0] r,
                                    output logic c, output logic v);
        int ua, ub, sa, sb, ur, sr;
        ua = int'(t.a); ub = int'(t.b);
        sa = int'($signed(t.a)); sb = int'($signed(t.b));
        c = 1'b0; v = 1'b0; r = 16'h0;
        if (t.sel) begin
            case (t.op)
                3'd0: r = t.a & t.b;
                3'd1: r = t.a | t.b;
                3'd2: r = t.a ^ t.b;
                3'd3: r = ~t.a;
                3'd4: r = ~(t.a & t.b);
                3'd5: r = ~(t.a | t.b);
                3'd6: r = ~(t.a ^ t.b);
                default: r = t.b;
            endcase
        end else begin
            ur = 0; sr = 0;
            case (t.op)
                3'd0: begin ur = ua + ub; sr = sa + sb; c = (ur > 65535); end
                3'd1: begin ur = ua - ub; sr = sa - sb; c = (ua < ub); end
                3'd2: begin ur = ua + 1;  sr = sa + 1;  c = (ur > 65535); end
                3'd3: begin ur = ua - 1;  sr = sa - 1;  c = (ua < 1); end
                3'd4: begin ur = ua * 2;  sr = sa * 2;  c = (ur > 65535); end
                3'd5: begin ur = ua / 2;  sr = 0;       c = (ua % 2) != 0; end
                3'd6: begin ur = sa >>> 1; sr = 0;      c = (ua % 2) != 0; end
                default: begin ur = ua; sr = 0; end
            endcase
            r = 16'(ur);
            v = (sr > 32767) || (sr < -32768);
        end
    endfunction

    // One clock cycle: drive inputs, sample #1 later, compare, advance the model.
    task automatic step();
        txn_t       t0, t1, acc;
        logic [1:0] exp_rdy, exp_vld;
        int         g;
        t0 = (q0.size() > 0) ? q0[0] : rnd_txn();
        t1 = (q1.size() > 0) ? q1[0] : rnd_txn();
        req_valid    = {q1.size() > 0, q0.size() > 0};
        req_select   = {t1.sel, t0.sel};
        req_opcode   = {t1.op, t0.op};
        req_arg1     = {t1.a, t0.a};
        req_arg2     = {t1.b, t0.b};
        rsp_ready    = rsp_rand ? 2'($urandom) : rsp_force;
        fp_req_valid = (fp_win > 0) ? 2'b11 : 2'b00;
        #1;
        cyc++;
        if (!rst_n) begin
            check("rst_req_ready", 32'(req_ready), 32'h0);
            if (in_rst) begin
                check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
                check("rst_busy", 32'(busy), 32'h0);
                check("rst_ops", 32'(ops_done), 32'h0);
            end
            in_rst = 1'b1; m_owner = -1; m_ops = 16'h0; m_last = 1'b1;
        end else begin
            in_rst = 1'b0;
            g = -1;
            if (m_owner < 0) begin
                if (q0.size() > 0 && q1.size() > 0) g = m_last ? 0 : 1;
                else if (q0.size() > 0) g = 0;
                else if (q1.size() > 0) g = 1;
            end
            exp_rdy = (g < 0) ? 2'b00 : (g == 0 ? 2'b01 : 2'b10);
            exp_vld = (m_owner >= 0 && cyc >= m_rsp_at) ? (m_owner == 0 ? 2'b01 : 2'b10) : 2'b00;
            check("req_ready", 32'(req_ready), 32'(exp_rdy));
            check("rsp_valid", 32'(rsp_valid), 32'(exp_vld));
            check("busy", 32'(busy), 32'(m_owner >= 0));
            check("ops_done", 32'(ops_done), 32'(m_ops));
            if (req_ready == 2'b01) glog.push_back(0);
            else if (req_ready == 2'b10) glog.push_back(1);
            else if (req_ready != 2'b00) glog.push_back(9);
            if (exp_vld != 2'b00) begin
                check("rsp_result", 32'(rsp_result), 32'(m_res));
                check("rsp_carry", 32'(rsp_carry), 32'(m_c));
                check("rsp_overflow", 32'(rsp_overflow), 32'(m_v));
                if (rsp_ready[m_owner]) begin
                    last_res = rsp_result; last_c = rsp_carry; last_v = rsp_overflow;
                    m_ops = m_ops + 16'd1; m_last = (m_owner == 1); m_owner = -1;
                end
            end
            if (g >= 0) begin
                acc = (g == 0) ? q0.pop_front() : q1.pop_front();
                ref_alu(acc, m_res, m_c, m_v);
                m_owner = g; m_rsp_at = cyc + 2;
            end
        end
        if (fp_win > 0) begin
            if (fp_req_ready == 2'b01) fp_p0++;
            else if (fp_req_ready != 2'b00) fp_p1++;
            fp_win--;
        end
        @(negedge clk);
    endtask

    task automatic drain(input int max);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || m_owner >= 0) && n < max) begin
            step(); n++;
        end
        check("drain_timeout", 32'(n < max), 32'h1);
    endtask

    initial begin
        int base, n;
        n_cmp = 0; n_err = 0; cyc = 0; in_rst = 1'b0;
        m_owner = -1; m_rsp_at = 0; m_last = 1'b1; m_ops = 16'h0; m_res = 16'h0;
        m_c = 1'b0; m_v = 1'b0; last_res = 16'h0; last_c = 1'b0; last_v = 1'b0;
        fp_win = 0; fp_p0 = 0; fp_p1 = 0;
        rsp_rand = 1'b0; rsp_force = 2'b11; rst_n = 1'b0;

        // Reset for two cycles, then idle
        repeat (2) step();
        rst_n = 1'b1;
        repeat (5) step();

        // Round-robin contention plus fixed-priority twin
        q0.push_back(mk(1'b0, ALU_OP_ADD, 16'h0010, 16'h0020));
        q0.push_back(mk(1'b0, ALU_OP_SUB, 16'h0003, 16'h0005));
        q1.push_back(mk(1'b1, ALU_OP_XOR, 16'hAAAA, 16'h5555));
        q1.push_back(mk(1'b0, ALU_OP_SHL, 16'h4000, 16'h0000));
        glog.delete();
        fp_win = 30;
        drain(100);
        while (fp_win > 0) step();
        check("rr_count", 32'(glog.size()), 32'd4);
        for (int i = 0; i < 4; i++) check("rr_order", 32'(glog[i]), 32'(i % 2));
        check("rr_ops_done", 32'(ops_done), 32'd4);
        check("fp_port0_grants", 32'(fp_p0), 32'd10);
        check("fp_port1_grants", 32'(fp_p1), 32'd0);

        // Add with signed overflow, then with carry out
        q0.push_back(mk(ALU_SEL_AU, ALU_OP_ADD, 16'h7FFF, 16'h0001));
        drain(20);
        check("add_ovf_result", 32'(last_res), 32'h8000);
        check("add_ovf_flag", 32'(last_v), 32'h1);
        check("add_ovf_carry", 32'(last_c), 32'h0);
        q0.push_back(mk(ALU_SEL_AU, ALU_OP_ADD, 16'hFFFF, 16'h0001));
        drain(20);
        check("add_cy_result", 32'(last_res), 32'h0000);
        check("add_cy_carry", 32'(last_c), 32'h1);

        // Logic op clears flags
        q1.push_back(mk(ALU_SEL_LU, ALU_OP_AND, 16'hF0F0, 16'hFF00));
        drain(20);
        check("and_result", 32'(last_res), 32'hF000);
        check("and_carry", 32'(last_c), 32'h0);
        check("and_overflow", 32'(last_v), 32'h0);

        // Back-pressure on port 0 while port 1 waits
        rsp_force = 2'b10;
        base = glog.size();
        q0.push_back(mk(ALU_SEL_AU, ALU_OP_SUB, 16'h8000, 16'h0001));
        step();
        q1.push_back(mk(ALU_SEL_AU, ALU_OP_INC, 16'h7FFF, 16'h0000));
        repeat (8) step();
        check("bp_grants_held", 32'(glog.size() - base), 32'd1);
        check("bp_rsp_valid", 32'(rsp_valid), 32'h1);
        rsp_force = 2'b11;
        drain(20);
        check("bp_after_count", 32'(glog.size() - base), 32'd2);
        if (glog.size() - base == 2) check("bp_after_order", 32'(glog[base + 1]), 32'd1);

        // Reset while a port-1 response waits
        rsp_force = 2'b01;
        q1.push_back(mk(ALU_SEL_AU, ALU_OP_DEC, 16'h0000, 16'h0000));
        n = 0;
        while (!(m_owner == 1 && cyc >= m_rsp_at) && n < 10) begin step(); n++; end
        check("rst_resp_reached", 32'(rsp_valid), 32'h2);
        q0.push_back(mk(ALU_SEL_AU, ALU_OP_ASR, 16'h8001, 16'h0000));
        q1.push_back(mk(ALU_SEL_LU, ALU_OP_NOR, 16'h0F0F, 16'h00FF));
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        rsp_force = 2'b11;
        check("rst_mid_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_mid_ops", 32'(ops_done), 32'h0);
        base = glog.size();
        drain(30);
        if (glog.size() > base) check("rst_first_grant", 32'(glog[base]), 32'd0);
        else check("rst_first_grant", 32'(glog.size() - base), 32'd1);

        // Randomised traffic with random response back-pressure
        rsp_rand = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if (q0.size() == 0 && $urandom_range(0, 3) == 0) q0.push_back(rnd_txn());
            if (q1.size() == 0 && $urandom_range(0, 3) == 0) q1.push_back(rnd_txn());
            step();
        end
        rsp_rand = 1'b0; rsp_force = 2'b11;
        drain(50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
